clkbuf_sink_monitor: RTL and testbench
======================================

Name: clkbuf_sink_monitor

Overview:
- Sits at the sink end of a buffered clock-tree branch. Samples the buffered clock (a divided or slow tap) as data in the local CLK domain.
- Counts its rising edges over a fixed window of CLK cycles and reports the count.
- Flags a dead branch (LOST) and an out-of-range frequency (sticky FAULT).
- Used on test/bring-up macros to verify clock-buffer chains from the receiving end.

Parameters:
- WINDOW, 16: window length in CLK cycles; must be ≥ 4.
- CNT_W, 8: width of the edge counter and the COUNT, LO and HI ports.
- SYNC_STAGES, 2: flops in the synchronizer for A; must be ≥ 2.

Ports:
- CLK  input  1  local system clock; all state on rising edge.
- RN  input  1  asynchronous active-low reset.
- EN  input  1  measurement enable.
- A  input  1  monitored buffered-clock tap; asynchronous; must be slower than CLK/2.
- LO  input  CNT_W  minimum acceptable edges per window.
- HI  input  CNT_W  maximum acceptable edges per window.
- CLR  input  1  clears FAULT.
- COUNT  output  CNT_W  edge count of the last completed window.
- VALID  output  1  one-cycle pulse when COUNT updates.
- LOST  output  1  last completed window had zero edges.
- FAULT  output  1  sticky range-violation flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are CLK and RN.
- Reset values:
  - Synchronizer, edge-detect previous flop, window counter, edge counter: all 0.
  - COUNT=0, VALID=0, LOST=0, FAULT=0, armed=0.
- Synchronizer and edge detect:
  - A passes through SYNC_STAGES flops, then a previous-value flop.
  - Rising edge = sync_out=1 and prev=0.
  - A rising edge on A is seen SYNC_STAGES+1 CLK cycles later.
  - The synchronizer runs regardless of EN.
- Arming:
  - armed sets SYNC_STAGES+1 cycles after RN deasserts.
  - Edges are ignored while armed=0, so a constant-high A at reset does not create a false edge.
- Window counter:
  - Counts 0..WINDOW-1 while EN=1; terminal cycle is WINDOW-1.
  - EN=0: window and edge counters forced to 0. COUNT/LOST/FAULT hold. VALID=0.
  - EN re-asserted: a fresh window starts at 0.
- Edge counter:
  - Increments on each qualified edge while EN=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - An edge in the terminal cycle counts toward the closing window.
- Terminal cycle, registered on the next edge:
  - COUNT ← final edge count; VALID=1 for exactly one cycle.
  - Edge counter restarts at 0.
  - LOST ← (final count == 0).
  - FAULT ← 1 if count < LO or count > HI, otherwise holds.
- Pulse rate: VALID pulses exactly every WINDOW cycles while EN is steady high.
- CLR:
  - Clears FAULT the next cycle.
  - If CLR coincides with a window close that detects a violation, set wins and FAULT=1.
- LO > HI: every window faults. This is legal and not checked.
- RN asserted mid-window: everything returns to reset values immediately. The partial window is discarded; no VALID.

Optional Feature:
- Macro: CLKMON_LOSS_TIMEOUT_EN.
- Enabled:
  - Adds parameter LOSS_TO (default 2*WINDOW) and an idle counter that clears on each qualified edge.
  - When the idle counter reaches LOSS_TO with EN=1, LOST asserts immediately, without waiting for window close.
  - It clears at the next window close with a nonzero count.
  - The idle counter saturates and is cleared by EN=0.
- Disabled: LOST updates only at window close; no extra state.

Test Plan:
- WINDOW=16, EN=1, A toggling every 2 CLK cycles (period 4), LO=3, HI=5 → VALID every 16 cycles after the first window, COUNT=4, LOST=0, FAULT=0.
- A held at 0, EN=1 → first window close gives COUNT=0, LOST=1, VALID pulse. FAULT=1 when LO=1.
- A period 2 CLK cycles, HI=5 → COUNT=8, FAULT=1. Then A period 4 → COUNT=4, FAULT stays 1 until CLR pulse, then 0. Also a CLR on a violating close → FAULT=1.
- A high during reset and after release, EN=1 → no edge counted: COUNT=0 at first close. Also drop EN for 5 cycles mid-window → no VALID during the gap; the next VALID comes 16 cycles after EN re-asserts.
- CNT_W=3, A period 2 over WINDOW=32 → COUNT saturates at 7. Assert RN at window cycle 10 → all outputs 0 immediately, no VALID.
- With CLKMON_LOSS_TIMEOUT_EN, LOSS_TO=20: stop A mid-window → LOST=1 exactly 20 cycles after the last qualified edge, before window close. Restart A → LOST=0 at the next nonzero close.

Source files
------------

// File: rtl/clkbuf_sink_monitor.sv
// Counts rising edges of a buffered clock tap per WINDOW-cycle window; flags dead branch (LOST) and sticky out-of-range (FAULT).
// Optional macro CLKMON_LOSS_TIMEOUT_EN adds an idle timeout (LOSS_TO) that raises LOST before the window closes.
module clkbuf_sink_monitor #(
    parameter int WINDOW      = 16,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
`ifdef CLKMON_LOSS_TIMEOUT_EN
    ,
    parameter int LOSS_TO     = 2 * WINDOW
`endif
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             A,
    input  logic [CNT_W-1:0] LO,
    input  logic [CNT_W-1:0] HI,
    input  logic             CLR,
    output logic [CNT_W-1:0] COUNT,
    output logic             VALID,
    output logic             LOST,
    output logic             FAULT
);

    localparam int               WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [SYNC_STAGES:0]   r_arm;
    logic [WIN_W-1:0]       r_win;
    logic [CNT_W-1:0]       r_edges;
    logic [CNT_W-1:0]       r_count;
    logic                   r_valid;
    logic                   r_lost;
    logic                   r_fault;

    logic                   w_rise;
    logic                   w_term;
    logic [CNT_W-1:0]       w_final;
    logic                   w_viol;
    logic                   w_lost_nxt;

    // Arming delay matches the synchronizer depth so a tap already high at reset is not seen as an edge.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_arm  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], A};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_arm  <= {r_arm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_rise  = r_sync[SYNC_STAGES-1] & ~r_prev & r_arm[SYNC_STAGES];
    assign w_term  = EN && (r_win == WIN_LAST);
    assign w_final = (r_edges == CNT_MAX) ? r_edges : r_edges + CNT_W'(w_rise);
    assign w_viol  = (w_final < LO) || (w_final > HI);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_win   <= '0;
            r_edges <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (!EN) begin
            r_win   <= '0;
            r_edges <= '0;
            r_valid <= 1'b0;
        end else if (w_term) begin
            r_win   <= '0;
            r_edges <= '0;
            r_count <= w_final;
            r_valid <= 1'b1;
        end else begin
            r_win   <= r_win + WIN_W'(1);
            r_edges <= w_final;
            r_valid <= 1'b0;
        end
    end

    // A violating close beats a coincident CLR.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_fault <= 1'b0;
        end else if (w_term && w_viol) begin
            r_fault <= 1'b1;
        end else if (CLR) begin
            r_fault <= 1'b0;
        end
    end

`ifdef CLKMON_LOSS_TIMEOUT_EN
    localparam int                IDLE_W   = $clog2(LOSS_TO + 1);
    localparam logic [IDLE_W-1:0] IDLE_TO  = IDLE_W'(LOSS_TO);
    localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(LOSS_TO - 1);

    logic [IDLE_W-1:0] r_idle;
    logic              w_timeout;

    assign w_timeout = EN && !w_rise && (r_idle == IDLE_PRE);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_idle <= '0;
        end else if (!EN || w_rise) begin
            r_idle <= '0;
        end else if (r_idle != IDLE_TO) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    assign w_lost_nxt = w_timeout | (w_term ? (w_final == '0) : r_lost);
`else
    assign w_lost_nxt = w_term ? (w_final == '0) : r_lost;
`endif

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_lost <= 1'b0;
        end else begin
            r_lost <= w_lost_nxt;
        end
    end

    assign COUNT = r_count;
    assign VALID = r_valid;
    assign LOST  = r_lost;
    assign FAULT = r_fault;

endmodule

// File: tb/tb_clkbuf_sink_monitor.sv
// Directed bench for clkbuf_sink_monitor; expected window results are queued per instance and popped on each VALID.
module tb_clkbuf_sink_monitor;

    typedef struct packed {
        logic       care;
        logic [7:0] cnt;
        logic       lost;
        logic       fault;
    } exp_t;

    logic       clk = 1'b0;
    logic       rn, rn1, en0, en1, en2, a, clr;
    logic [7:0] lo, hi;
    logic [2:0] lo1, hi1;
    logic [7:0] count0;
    logic       valid0, lost0, fault0;
    logic [2:0] count1;
    logic       valid1, lost1, fault1;
    logic [7:0] count2;
    logic       valid2, lost2, fault2;

    int   checks   = 0;
    int   failures = 0;
    int   a_half   = 0;
    int   a_cnt    = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [2:0] vld_seen;

    always #5 clk = ~clk;

    clkbuf_sink_monitor #(.WINDOW(16), .CNT_W(8), .SYNC_STAGES(2)) u_dut0 (
        .CLK(clk), .RN(rn), .EN(en0), .A(a), .LO(lo), .HI(hi), .CLR(clr),
        .COUNT(count0), .VALID(valid0), .LOST(lost0), .FAULT(fault0));

    clkbuf_sink_monitor #(.WINDOW(32), .CNT_W(3), .SYNC_STAGES(2)) u_dut1 (
        .CLK(clk), .RN(rn1), .EN(en1), .A(a), .LO(lo1), .HI(hi1), .CLR(clr),
        .COUNT(count1), .VALID(valid1), .LOST(lost1), .FAULT(fault1));

`ifdef CLKMON_LOSS_TIMEOUT_EN
    clkbuf_sink_monitor #(.WINDOW(16), .CNT_W(8), .SYNC_STAGES(2), .LOSS_TO(20)) u_dut2 (
        .CLK(clk), .RN(rn), .EN(en2), .A(a), .LO(lo), .HI(hi), .CLR(clr),
        .COUNT(count2), .VALID(valid2), .LOST(lost2), .FAULT(fault2));
`else
    assign count2 = '0;
    assign valid2 = 1'b0;
    assign lost2  = 1'b0;
    assign fault2 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic has, input exp_t e, input logic [9:0] obs);
        checks++;
        assert (has === 1'b1) else begin
            failures++;
            $error("FAIL %s unexpected VALID observed=1 expected=0", tag);
        end
        if (has && e.care) begin
            checks++;
            assert (obs === {e.cnt, e.lost, e.fault}) else begin
                failures++;
                $error("FAIL %s {count,lost,fault} observed=%0h expected=%0h", tag, obs, {e.cnt, e.lost, e.fault});
            end
        end
    endtask

    // One clock: drive the tap after the edge, then sample outputs on the falling edge.
    task automatic tick();
        exp_t e;
        logic has;
        @(posedge clk);
        #1;
        if (a_half != 0) begin
            a_cnt++;
            if (a_cnt >= a_half) begin
                a     = ~a;
                a_cnt = 0;
            end
        end
        @(negedge clk);
        vld_seen = '0;
        if (valid0) begin
            vld_seen[0] = 1'b1;
            has = (q0.size() != 0);
            e   = '0;
            if (has) e = q0.pop_front();
            sb_check("dut0_window", has, e, {count0, lost0, fault0});
        end
        if (valid1) begin
            vld_seen[1] = 1'b1;
            has = (q1.size() != 0);
            e   = '0;
            if (has) e = q1.pop_front();
            sb_check("dut1_window", has, e, {5'b0, count1, lost1, fault1});
        end
        if (valid2) begin
            vld_seen[2] = 1'b1;
            has = (q2.size() != 0);
            e   = '0;
            if (has) e = q2.pop_front();
            sb_check("dut2_window", has, e, {count2, lost2, fault2});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int d, input int exp_n, input string tag);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < exp_n + 40) begin
            tick();
            n++;
            got = vld_seen[d];
        end
        if (!got) n = -1;
        chk(tag, n, exp_n);
    endtask

    function automatic exp_t mk(input logic care, input logic [7:0] cnt, input logic lost, input logic fault);
        exp_t e;
        e.care  = care;
        e.cnt   = cnt;
        e.lost  = lost;
        e.fault = fault;
        return e;
    endfunction

    initial begin
        rn = 1'b0; rn1 = 1'b0; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        a = 1'b0; clr = 1'b0; lo = 8'd0; hi = 8'd255; lo1 = 3'd0; hi1 = 3'd7;
        vld_seen = '0;
        ticks(3);
        chk("rst_count", count0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_lost",  lost0,  0);
        chk("rst_fault", fault0, 0);
        chk("rst_count1", count1, 0);

        // Period-4 tap: 4 edges per 16-cycle window, VALID every 16 cycles.
        a_half = 2; a_cnt = 0;
        rn = 1'b1; rn1 = 1'b1; en0 = 1'b1;
        q0.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0));
        wait_valid(0, 16, "first_window_gap");
        lo = 8'd3; hi = 8'd5;
        q0.push_back(mk(1'b1, 8'd4, 1'b0, 1'b0));
        wait_valid(0, 16, "p4_gap_a");
        q0.push_back(mk(1'b1, 8'd4, 1'b0, 1'b0));
        wait_valid(0, 16, "p4_gap_b");

        // Dead tap with LO=1: zero count, LOST and FAULT.
        en0 = 1'b0; a_half = 0; a = 1'b0; lo = 8'd1;
        ticks(5);
        en0 = 1'b1;
        q0.push_back(mk(1'b1, 8'd0, 1'b1, 1'b1));
        wait_valid(0, 16, "dead_gap");
        en0 = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_fault", fault0, 0);
        chk("lost_hold_en0", lost0, 1);

        // Period-2 tap over HI=5 faults; sticky through good windows until CLR.
        lo = 8'd3; hi = 8'd5; a_half = 1; a_cnt = 0;
        ticks(5);
        en0 = 1'b1;
        q0.push_back(mk(1'b1, 8'd8, 1'b0, 1'b1));
        wait_valid(0, 16, "p2_gap");
        en0 = 1'b0; a_half = 2; a_cnt = 0;
        ticks(5);
        en0 = 1'b1;
        q0.push_back(mk(1'b1, 8'd4, 1'b0, 1'b1));
        wait_valid(0, 16, "sticky_gap_a");
        q0.push_back(mk(1'b1, 8'd4, 1'b0, 1'b1));
        wait_valid(0, 16, "sticky_gap_b");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_mid_window", fault0, 0);
        q0.push_back(mk(1'b1, 8'd4, 1'b0, 1'b0));
        wait_valid(0, 15, "after_clr_gap");

        // CLR in the terminal cycle of a violating window: set wins.
        en0 = 1'b0; a_half = 1; a_cnt = 0;
        ticks(5);
        en0 = 1'b1;
        ticks(15);
        clr = 1'b1;
        q0.push_back(mk(1'b1, 8'd8, 1'b0, 1'b1));
        wait_valid(0, 1, "clr_vs_set_gap");
        clr = 1'b0;

        // Tap high through reset and after release: no false edge.
        rn = 1'b0; en0 = 1'b0; a_half = 0; a = 1'b1;
        #1;
        chk("async_rst_fault", fault0, 0);
        chk("async_rst_count", count0, 0);
        ticks(2);
        lo = 8'd0; hi = 8'd5;
        rn = 1'b1; en0 = 1'b1;
        q0.push_back(mk(1'b1, 8'd0, 1'b1, 1'b0));
        wait_valid(0, 16, "high_at_reset_gap");

        // EN dropped for 5 cycles mid-window: fresh 16-cycle window afterwards.
        lo = 8'd0; hi = 8'd255; a_half = 2; a_cnt = 0;
        q0.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0));
        wait_valid(0, 16, "restart_gap");
        lo = 8'd3; hi = 8'd5;
        ticks(6);
        en0 = 1'b0;
        ticks(5);
        chk("valid_en_low", valid0, 0);
        en0 = 1'b1;
        q0.push_back(mk(1'b1, 8'd4, 1'b0, 1'b0));
        wait_valid(0, 16, "en_gap");
        en0 = 1'b0;

        // 3-bit counter saturates at 7; reset mid-window discards the window.
        a_half = 1; a_cnt = 0; en1 = 1'b1;
        q1.push_back(mk(1'b1, 8'd7, 1'b0, 1'b0));
        wait_valid(1, 32, "sat_gap_a");
        q1.push_back(mk(1'b1, 8'd7, 1'b0, 1'b0));
        wait_valid(1, 32, "sat_gap_b");
        ticks(10);
        rn1 = 1'b0;
        #1;
        chk("rst_mid_count", count1, 0);
        chk("rst_mid_valid", valid1, 0);
        chk("rst_mid_lost",  lost1,  0);
        chk("rst_mid_fault", fault1, 0);
        ticks(40);
        chk("rst_mid_no_valid", vld_seen[1], 0);
        en1 = 1'b0;

`ifdef CLKMON_LOSS_TIMEOUT_EN
        // Idle timeout of 20 cycles raises LOST ahead of the window close.
        lo = 8'd0; hi = 8'd255; a_half = 2; a_cnt = 0; en2 = 1'b1;
        q2.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0));
        wait_valid(2, 16, "loss_first_gap");
        a_half = 0; a = 1'b0;
        q2.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0));
        ticks(5);
        a = 1'b1;
        tick();
        a = 1'b0;
        ticks(21);
        chk("loss_before_to", lost2, 0);
        tick();
        chk("loss_at_to", lost2, 1);
        q2.push_back(mk(1'b1, 8'd0, 1'b1, 1'b0));
        wait_valid(2, 4, "loss_close_gap");
        a_half = 2; a_cnt = 0;
        q2.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0));
        ticks(15);
        chk("loss_held", lost2, 1);
        wait_valid(2, 1, "loss_clear_gap");
        chk("loss_cleared", lost2, 0);
        en2 = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
